// File: rtl/if_id_pipe_stage.sv
// IF/ID pipeline stage: valid/ready handshake with a 2-entry skid buffer and flush-to-bubble.
// Define IF_ID_PERF_CNT_EN to add the saturating stall_cnt / flush_cnt performance counters.
module if_id_pipe_stage #(
  parameter int unsigned INST_W = 32,
  parameter int unsigned ADDR_W = 64,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'hD503201F)
`ifdef IF_ID_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] Inst_IF,
  input  logic [ADDR_W-1:0] PC_out_IF,
  input  logic [ADDR_W-1:0] Add_4_IF,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] Inst_ID,
  output logic [ADDR_W-1:0] PC_out_ID,
  output logic [ADDR_W-1:0] Add_4_ID
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic [INST_W-1:0]   main_inst_q, main_inst_d, skid_inst_q, skid_inst_d;
  logic [ADDR_W-1:0]   main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [ADDR_W-1:0]   main_a4_q, main_a4_d, skid_a4_q, skid_a4_d;
  logic                in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = (state_q != StEmpty) & out_ready;

  always_comb begin
    state_d     = state_q;
    main_inst_d = main_inst_q;
    main_pc_d   = main_pc_q;
    main_a4_d   = main_a4_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_a4_d   = skid_a4_q;
    unique case (state_q)
      StEmpty: begin
        if (in_fire) begin
          state_d     = StOne;
          main_inst_d = Inst_IF;
          main_pc_d   = PC_out_IF;
          main_a4_d   = Add_4_IF;
        end
      end
      StOne: begin
        if (in_fire && out_fire) begin
          main_inst_d = Inst_IF;
          main_pc_d   = PC_out_IF;
          main_a4_d   = Add_4_IF;
        end else if (in_fire) begin
          state_d     = StTwo;
          skid_inst_d = Inst_IF;
          skid_pc_d   = PC_out_IF;
          skid_a4_d   = Add_4_IF;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (out_fire) begin
          state_d     = StOne;
          main_inst_d = skid_inst_q;
          main_pc_d   = skid_pc_q;
          main_a4_d   = skid_a4_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush discards any entry loaded this cycle; PC fields keep the old main values.
    if (flush) begin
      state_d   = StEmpty;
      main_pc_d = main_pc_q;
      main_a4_d = main_a4_q;
    end
    if (state_d == StEmpty) begin
      main_inst_d = NOP_INST;
    end
    in_ready_d = (state_d != StTwo);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      main_inst_q <= NOP_INST;
      main_pc_q   <= '0;
      main_a4_q   <= '0;
      skid_inst_q <= '0;
      skid_pc_q   <= '0;
      skid_a4_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_inst_q <= main_inst_d;
      main_pc_q   <= main_pc_d;
      main_a4_q   <= main_a4_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_a4_q   <= skid_a4_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != StEmpty);
  assign Inst_ID   = main_inst_q;
  assign PC_out_ID = main_pc_q;
  assign Add_4_ID  = main_a4_q;

`ifdef IF_ID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !out_ready && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush && (out_valid || in_fire) && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// Bench for if_id_pipe_stage: directed vector table, then random traffic against a queue model.
module tb_if_id_pipe_stage;

  localparam logic [31:0] NOP = 32'hD503201F;
  localparam int unsigned CNT_W = 4;
  localparam int NVEC = 22;
  localparam int NRAND = 600;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] Inst_IF, Inst_ID;
  logic [63:0] PC_out_IF, Add_4_IF, PC_out_ID, Add_4_ID;
`ifdef IF_ID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  if_id_pipe_stage #(
    .INST_W(32),
    .ADDR_W(64),
    .NOP_INST(32'hD503201F)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .Inst_IF(Inst_IF),
    .PC_out_IF(PC_out_IF),
    .Add_4_IF(Add_4_IF),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Inst_ID(Inst_ID),
    .PC_out_ID(PC_out_ID),
    .Add_4_ID(Add_4_ID)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rn, iv, fl, ordy;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        ev, er;
    logic [31:0] einst;
    logic [63:0] epc, ea4;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc, a4;
  } ent_t;

  vec_t tbl[NVEC];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic rn, logic iv, logic fl, logic ordy, logic [31:0] inst,
                              logic [63:0] pc, logic ev, logic er, logic [31:0] einst,
                              logic [63:0] epc, logic [63:0] ea4);
    vec_t v;
    v.rn = rn; v.iv = iv; v.fl = fl; v.ordy = ordy; v.inst = inst; v.pc = pc;
    v.ev = ev; v.er = er; v.einst = einst; v.epc = epc; v.ea4 = ea4;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_outs(input int idx, input logic ev, input logic er, input logic [31:0] ei,
                          input logic [63:0] ep, input logic [63:0] ea);
    chk("out_valid", idx, 64'(out_valid), 64'(ev));
    chk("in_ready", idx, 64'(in_ready), 64'(er));
    chk("Inst_ID", idx, 64'(Inst_ID), 64'(ei));
    chk("PC_out_ID", idx, PC_out_ID, ep);
    chk("Add_4_ID", idx, Add_4_ID, ea);
  endtask

  initial begin
    ent_t        q[$];
    ent_t        e;
    logic [63:0] shown_pc, shown_a4;
    logic        inf, outf;
    int          stall_m, flush_m;

    // Reset held with traffic present
    tbl[0]  = mk(0, 1, 0, 1, 32'h11, 64'h50,  0, 1, NOP,   64'h0,   64'h0);
    tbl[1]  = mk(0, 1, 0, 1, 32'h12, 64'h54,  0, 1, NOP,   64'h0,   64'h0);
    // Streaming
    tbl[2]  = mk(1, 1, 0, 1, 32'hA,  64'h100, 1, 1, 32'hA, 64'h100, 64'h104);
    tbl[3]  = mk(1, 1, 0, 1, 32'hB,  64'h104, 1, 1, 32'hB, 64'h104, 64'h108);
    tbl[4]  = mk(1, 1, 0, 1, 32'hC,  64'h108, 1, 1, 32'hC, 64'h108, 64'h10C);
    tbl[5]  = mk(1, 0, 0, 1, 32'h0,  64'h0,   0, 1, NOP,   64'h108, 64'h10C);
    // Backpressure
    tbl[6]  = mk(1, 1, 0, 0, 32'h20, 64'h200, 1, 1, 32'h20, 64'h200, 64'h204);
    tbl[7]  = mk(1, 1, 0, 0, 32'h21, 64'h204, 1, 0, 32'h20, 64'h200, 64'h204);
    tbl[8]  = mk(1, 1, 0, 0, 32'h22, 64'h208, 1, 0, 32'h20, 64'h200, 64'h204);
    tbl[9]  = mk(1, 0, 0, 1, 32'h0,  64'h0,   1, 1, 32'h21, 64'h204, 64'h208);
    tbl[10] = mk(1, 0, 0, 1, 32'h0,  64'h0,   0, 1, NOP,    64'h204, 64'h208);
    // Flush from TWO, then flush of an in_fire from ONE
    tbl[11] = mk(1, 1, 0, 0, 32'h30, 64'h300, 1, 1, 32'h30, 64'h300, 64'h304);
    tbl[12] = mk(1, 1, 0, 0, 32'h31, 64'h304, 1, 0, 32'h30, 64'h300, 64'h304);
    tbl[13] = mk(1, 1, 1, 0, 32'h32, 64'h308, 0, 1, NOP,    64'h300, 64'h304);
    tbl[14] = mk(1, 0, 0, 1, 32'h0,  64'h0,   0, 1, NOP,    64'h300, 64'h304);
    tbl[15] = mk(1, 1, 0, 0, 32'h33, 64'h310, 1, 1, 32'h33, 64'h310, 64'h314);
    tbl[16] = mk(1, 1, 1, 0, 32'h34, 64'h314, 0, 1, NOP,    64'h310, 64'h314);
    // Reset from TWO, then normal pass-through
    tbl[17] = mk(1, 1, 0, 0, 32'h40, 64'h320, 1, 1, 32'h40, 64'h320, 64'h324);
    tbl[18] = mk(1, 1, 0, 0, 32'h41, 64'h324, 1, 0, 32'h40, 64'h320, 64'h324);
    tbl[19] = mk(0, 1, 0, 0, 32'h42, 64'h328, 0, 1, NOP,    64'h0,   64'h0);
    tbl[20] = mk(1, 1, 0, 1, 32'h50, 64'h400, 1, 1, 32'h50, 64'h400, 64'h404);
    tbl[21] = mk(1, 0, 0, 1, 32'h0,  64'h0,   0, 1, NOP,    64'h400, 64'h404);

    for (int i = 0; i < NVEC; i++) begin
      reset     = tbl[i].rn;
      in_valid  = tbl[i].iv;
      flush     = tbl[i].fl;
      out_ready = tbl[i].ordy;
      Inst_IF   = tbl[i].inst;
      PC_out_IF = tbl[i].pc;
      Add_4_IF  = tbl[i].pc + 64'd4;
      @(posedge clk);
      #1;
      chk_outs(i, tbl[i].ev, tbl[i].er, tbl[i].einst, tbl[i].epc, tbl[i].ea4);
    end

    // Random traffic: the reference is an ordered queue of at most two entries
    shown_pc = '0;
    shown_a4 = '0;
    stall_m  = 0;
    flush_m  = 0;
    for (int i = 0; i < NRAND; i++) begin
      reset     = (i == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 11) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      Inst_IF   = $urandom;
      PC_out_IF = {$urandom, $urandom};
      Add_4_IF  = {$urandom, $urandom};
      if (!reset) begin
        q.delete();
        shown_pc = '0;
        shown_a4 = '0;
        stall_m  = 0;
        flush_m  = 0;
      end else begin
        inf  = in_valid && (q.size() < 2);
        outf = (q.size() > 0) && out_ready;
        if (q.size() > 0 && !out_ready && stall_m < (1 << CNT_W) - 1) stall_m++;
        if (flush && (q.size() > 0 || inf) && flush_m < (1 << CNT_W) - 1) flush_m++;
        if (outf) void'(q.pop_front());
        if (inf) begin
          e.inst = Inst_IF;
          e.pc   = PC_out_IF;
          e.a4   = Add_4_IF;
          q.push_back(e);
        end
        if (flush) q.delete();
        if (q.size() > 0) begin
          shown_pc = q[0].pc;
          shown_a4 = q[0].a4;
        end
      end
      @(posedge clk);
      #1;
      chk_outs(NVEC + i, q.size() > 0, q.size() < 2, (q.size() > 0) ? q[0].inst : NOP,
               shown_pc, shown_a4);
`ifdef IF_ID_PERF_CNT_EN
      chk("stall_cnt", NVEC + i, 64'(stall_cnt), 64'(stall_m));
      chk("flush_cnt", NVEC + i, 64'(flush_cnt), 64'(flush_m));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
